// File: rtl/button_event_arbiter.sv
// Round-robin arbiter that queues debounced button presses as event codes in a show-ahead FIFO.
// Optional sticky coalesced-press flag is compiled in with `define BTN_OVERFLOW_FLAG_EN.
module button_event_arbiter #(
  parameter int N_BTN  = 4,
  parameter int CODE_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_BTN-1:0]           btn_pulse,
  output logic                       evt_valid,
  output logic [CODE_W-1:0]          evt_code,
  input  logic                       evt_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [N_BTN-1:0]  pending_q, pending_d;
  logic [CODE_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [CODE_W-1:0] mem_q [DEPTH];

  logic              full, pop, gnt_vld;
  logic [CODE_W-1:0] gnt_idx;
  logic [N_BTN-1:0]  gnt_oh;
  int                j;

  assign full = (count_q == (AW+1)'(DEPTH));
  assign pop  = (count_q != '0) && evt_ready;

  // First pending button at or after rr_ptr, wrapping; a full FIFO blocks the grant even if popping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    j       = 0;
    for (int k = 0; k < N_BTN; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_BTN) j = j - N_BTN;
      if (!gnt_vld && !full && pending_q[j]) begin
        gnt_vld   = 1'b1;
        gnt_idx   = CODE_W'(j);
        gnt_oh[j] = 1'b1;
      end
    end
  end

  // A pulse on the granted button re-arms its pending bit as a fresh event.
  assign pending_d = (pending_q & ~gnt_oh) | btn_pulse;
  assign rr_ptr_d  = (gnt_idx == CODE_W'(N_BTN-1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    count_d = count_q;
    if (gnt_vld && !pop)      count_d = count_q + 1'b1;
    else if (!gnt_vld && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      if (gnt_vld) begin
        rr_ptr_q <= rr_ptr_d;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_vld) mem_q[wr_ptr_q] <= gnt_idx;
  end

  assign evt_valid  = (count_q != '0);
  assign evt_code   = evt_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;

`ifdef BTN_OVERFLOW_FLAG_EN
  logic overflow_q;
  logic coalesce;
  // A press on a button still waiting for its grant folds into the existing event.
  assign coalesce = |(btn_pulse & pending_q & ~gnt_oh);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           overflow_q <= 1'b0;
    else if (coalesce) overflow_q <= 1'b1;
  end
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter; expected codes queued at stimulus time, checked on pop.
module tb_button_event_arbiter;
  localparam int N_BTN = 4, CODE_W = 2, DEPTH = 4;
`ifdef BTN_OVERFLOW_FLAG_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_BTN-1:0]  btn_pulse = '0;
  logic              evt_ready = 1'b0;
  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic [$clog2(DEPTH):0] fifo_count;
  logic              overflow;

  int checks = 0, errors = 0;
  logic [CODE_W-1:0] sb[$];
  logic [CODE_W-1:0] exp_code;

  button_event_arbiter #(.N_BTN(N_BTN), .CODE_W(CODE_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_ready(evt_ready), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N_BTN-1:0] m);
    btn_pulse = m;
    tick(1);
    btn_pulse = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    sb.delete();
    tick(1);
    rst = 1'b0;
  endtask

  // Consumer side: every accepted head is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (sb.size() == 0) chk("pop_unexp", sb.size(), 1);
      else begin
        exp_code = sb.pop_front();
        chk("pop_code", evt_code, exp_code);
      end
    end
  end

  initial begin
    tick(2);
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_code", evt_code, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick(1);

    // Isolated press on button 2: two-edge latency.
    btn_pulse = 4'b0100; sb.push_back(2);
    tick(1); btn_pulse = '0;
    chk("lat_valid_e1", evt_valid, 0);
    tick(1);
    chk("lat_valid_e2", evt_valid, 1);
    chk("lat_code", evt_code, 2);
    chk("lat_count", fifo_count, 1);
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    chk("lat_drain", fifo_count, 0);

    // All four at once, consumer always ready.
    reset_dut();
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back(CODE_W'(k));
    pulse(4'b1111);
    chk("all_valid_e1", evt_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("all_code", evt_code, k);
      chk("all_count", fifo_count, 1);
    end
    tick(1);
    chk("all_drain", fifo_count, 0);
    evt_ready = 1'b0;

    // Round-robin: after granting 1, button 3 beats button 0.
    sb.push_back(1); sb.push_back(3); sb.push_back(0);
    pulse(4'b0010);
    pulse(4'b1001);
    tick(2);
    chk("rr_count", fifo_count, 3);
    chk("rr_head", evt_code, 1);
    evt_ready = 1'b1; tick(3); evt_ready = 1'b0;
    chk("rr_drain", fifo_count, 0);

    // Full FIFO: grants blocked, repeated press on button 1 coalesces.
    sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(0); sb.push_back(1);
    pulse(4'b1111);
    tick(4);
    chk("full_count", fifo_count, 4);
    pulse(4'b0010);
    pulse(4'b0010);
    chk("full_hold", fifo_count, 4);
    chk("full_ovf", overflow, OVF);
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    chk("full_pop_only", fifo_count, 3);
    tick(1);
    chk("full_refill", fifo_count, 4);
    tick(2);
    chk("full_no_extra", fifo_count, 4);
    evt_ready = 1'b1; tick(5); evt_ready = 1'b0;
    chk("full_drain", fifo_count, 0);
    chk("full_ovf_sticky", overflow, OVF);

    // Press on the button being granted re-arms it without coalescing.
    reset_dut();
    chk("rst2_ovf", overflow, 0);
    sb.push_back(0); sb.push_back(0);
    pulse(4'b0001);
    pulse(4'b0001);
    chk("same_count1", fifo_count, 1);
    tick(1);
    chk("same_count2", fifo_count, 2);
    chk("same_ovf", overflow, 0);
    tick(2);
    chk("same_hold", fifo_count, 2);
    evt_ready = 1'b1; tick(2); evt_ready = 1'b0;
    chk("same_drain", fifo_count, 0);

    // Asynchronous reset mid-cycle with three events queued.
    pulse(4'b0111);
    tick(3);
    chk("ar_pre_count", fifo_count, 3);
    @(negedge clk); #2;
    rst = 1'b1; sb.delete();
    #1;
    chk("ar_valid", evt_valid, 0);
    chk("ar_count", fifo_count, 0);
    chk("ar_code", evt_code, 0);
    chk("ar_ovf", overflow, 0);
    tick(1);
    rst = 1'b0;
    evt_ready = 1'b1;
    tick(4);
    chk("ar_stale_valid", evt_valid, 0);
    chk("ar_stale_count", fifo_count, 0);
    sb.push_back(0); sb.push_back(3);
    pulse(4'b1001);
    tick(1);
    chk("ar_first_grant", evt_code, 0);
    tick(2);
    evt_ready = 1'b0;
    chk("ar_drain", fifo_count, 0);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
